press_classifier: RTL



---
 rtl/press_pkg.sv | 29 ++
 rtl/press_classifier_edge.sv | 32 +++
 rtl/press_classifier.sv | 128 ++++++++++++
 3 files changed

// File: rtl/press_pkg.sv
// rtl/press_pkg.sv - shared state encoding and default timing for the press classifier
package press_pkg;

    // State encoding (3-bit)
    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_PRESS1 = 3'd1;
    localparam logic [2:0] ENC_GAP    = 3'd2;
    localparam logic [2:0] ENC_PRESS2 = 3'd3;
    localparam logic [2:0] ENC_HELD   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_PRESS1 = ENC_PRESS1,
        ST_GAP    = ENC_GAP,
        ST_PRESS2 = ENC_PRESS2,
        ST_HELD   = ENC_HELD
    } press_state_t;

    // Default timing for a 25 MHz clock
    localparam int DEF_LONG_CLKS   = 12500000;  // 0.5 s
    localparam int DEF_GAP_CLKS    = 6250000;   // 250 ms
    localparam int DEF_REPEAT_CLKS = 2500000;   // 100 ms
    localparam int DEF_CNT_W       = 24;

    // The previous-level register starts "pressed", so a switch held
    // through reset never looks like a fresh press.
    localparam logic PREV_RESET = 1'b1;

endpackage

// File: rtl/press_classifier_edge.sv
// rtl/press_classifier_edge.sv - rise/fall detector for a synchronous level
//
// Module switch_edge_detect.
//   i_Clk    : clock
//   i_Rst_L  : synchronous active-low reset
//   i_Level  : synchronous level input
//   o_Rise   : level is 1 now and was 0 last cycle (combinational)
//   o_Fall   : level is 0 now and was 1 last cycle (combinational)
module switch_edge_detect
    import press_pkg::*;
(
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Level,
    output logic o_Rise,
    output logic o_Fall
);

    logic prev;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            prev <= PREV_RESET;
        end else begin
            prev <= i_Level;
        end
    end

    assign o_Rise = i_Level & ~prev;
    assign o_Fall = ~i_Level & prev;

endmodule

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classifies debounced button gestures as short, long or double presses
//
// Optional feature macro: PRESS_REPEAT_EN (auto-repeat of o_Long while held).
//   i_Clk     : clock
//   i_Rst_L   : synchronous active-low reset
//   i_Switch  : debounced switch level, 1 = pressed
//   o_Short   : one-cycle pulse, short single press completed
//   o_Long    : one-cycle pulse, long-press threshold reached (and repeats if enabled)
//   o_Double  : one-cycle pulse, double press completed
//   o_Busy    : registered, high while a gesture is in progress
module press_classifier
    import press_pkg::*;
#(
    parameter int LONG_CLKS   = DEF_LONG_CLKS,
    parameter int GAP_CLKS    = DEF_GAP_CLKS,
    parameter int REPEAT_CLKS = DEF_REPEAT_CLKS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Short,
    output logic o_Long,
    output logic o_Double,
    output logic o_Busy
);

`ifdef PRESS_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CLKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CLKS - 1);

    logic              rise;
    logic              fall;
    press_state_t      state;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  timer_inc;

    switch_edge_detect u_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Level (i_Switch),
        .o_Rise  (rise),
        .o_Fall  (fall)
    );

    // Saturating increment: a long PRESS2 hold must not wrap the timer.
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state    <= ST_IDLE;
            timer    <= '0;
            o_Short  <= 1'b0;
            o_Long   <= 1'b0;
            o_Double <= 1'b0;
            o_Busy   <= 1'b0;
        end else begin
            o_Short  <= 1'b0;
            o_Long   <= 1'b0;
            o_Double <= 1'b0;
            // Reflects the current state, so busy stays high for the
            // cycle in which the FSM lands back in IDLE.
            o_Busy   <= (state != ST_IDLE);
            timer    <= timer_inc;

            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (rise) begin
                        state <= ST_PRESS1;
                    end
                end
                ST_PRESS1: begin
                    // Release wins over the long threshold on the same cycle.
                    if (!i_Switch) begin
                        state <= ST_GAP;
                        timer <= '0;
                    end else if (timer == LONG_LAST) begin
                        state  <= ST_HELD;
                        timer  <= '0;
                        o_Long <= 1'b1;
                    end
                end
                ST_GAP: begin
                    // A second press wins over the gap timeout on the same cycle.
                    if (rise) begin
                        state <= ST_PRESS2;
                        timer <= '0;
                    end else if (timer == GAP_LAST) begin
                        state   <= ST_IDLE;
                        timer   <= '0;
                        o_Short <= 1'b1;
                    end
                end
                ST_PRESS2: begin
                    if (fall) begin
                        state    <= ST_IDLE;
                        timer    <= '0;
                        o_Double <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!REPEAT_EN) begin
                        timer <= '0;
                    end
                    if (fall) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end else if (REPEAT_EN && i_Switch && timer == REPEAT_LAST) begin
                        o_Long <= 1'b1;
                        timer  <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule
